// File: rtl/addsub_arbiter_if.sv
// Request/response channels between two requesters and the shared add/sub sequencer.
// The master side issues operand pairs and takes results; the slave side is the arbiter.
interface addsub_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req0_mode;

    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req1_mode;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [15:0] rsp_sum;
    logic        rsp_carry;
    logic        rsp_overflow;

    modport master (
        output req0_valid, req0_a, req0_b, req0_mode,
        output req1_valid, req1_a, req1_b, req1_mode,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_sum, rsp_carry, rsp_overflow,
        output rsp0_ready, rsp1_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_mode,
        input  req1_valid, req1_a, req1_b, req1_mode,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_sum, rsp_carry, rsp_overflow,
        input  rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin sequencer sharing one 16-bit add/sub unit between two requesters.
// Each op runs accept -> execute -> respond; priority flips to the other side after every response.

module addsub (
    input  logic [15:0] input_a,
    input  logic [15:0] input_b,
    input  logic        mode,
    output logic [15:0] sum,
    output logic        carry,
    output logic        overflow
);
    logic [15:0] b_eff;
    logic [14:0] sum_lo;
    logic        sum_hi;
    logic        c15;

    // Subtraction is A + ~B + 1; the mode bit doubles as the carry-in.
    assign b_eff           = mode ? ~input_b : input_b;
    assign {c15, sum_lo}   = {1'b0, input_a[14:0]} + {1'b0, b_eff[14:0]} + {15'd0, mode};
    assign {carry, sum_hi} = {1'b0, input_a[15]} + {1'b0, b_eff[15]} + {1'b0, c15};
    assign sum             = {sum_hi, sum_lo};
    assign overflow        = carry ^ c15;
endmodule

module addsub_arbiter (
    input  logic                 clk,
    input  logic                 reset,
    addsub_arbiter_if.slave      bus,
    output logic                 busy,
    output logic [7:0]           op_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic        prio;
    logic        grant_id;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_mode;
    logic [15:0] sum_q;
    logic        carry_q;
    logic        ovf_q;

    logic [15:0] alu_sum;
    logic        alu_carry;
    logic        alu_ovf;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        rsp_done;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !reset) begin
            if (bus.req0_valid && (!bus.req1_valid || !prio))
                grant0 = 1'b1;
            else if (bus.req1_valid)
                grant1 = 1'b1;
        end
    end

    assign accept   = grant0 | grant1;
    assign rsp_done = (state == RESP) && (grant_id ? bus.rsp1_ready : bus.rsp0_ready);

    addsub u_addsub (
        .input_a  (op_a),
        .input_b  (op_b),
        .mode     (op_mode),
        .sum      (alu_sum),
        .carry    (alu_carry),
        .overflow (alu_ovf)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= 1'b0;
            grant_id <= 1'b0;
            sum_q    <= 16'd0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            op_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_id <= grant1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    sum_q   <= alu_sum;
                    carry_q <= alu_carry;
                    ovf_q   <= alu_ovf;
                    state   <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        prio     <= ~grant_id;
                        op_count <= op_count + 8'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on accept before EXEC reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a    <= grant1 ? bus.req1_a    : bus.req0_a;
            op_b    <= grant1 ? bus.req1_b    : bus.req0_b;
            op_mode <= grant1 ? bus.req1_mode : bus.req0_mode;
        end
    end

    assign bus.req0_ready   = grant0;
    assign bus.req1_ready   = grant1;
    assign bus.rsp0_valid   = (state == RESP) && !grant_id;
    assign bus.rsp1_valid   = (state == RESP) && grant_id;
    assign bus.rsp_sum      = sum_q;
    assign bus.rsp_carry    = carry_q;
    assign bus.rsp_overflow = ovf_q;
    assign busy             = (state != IDLE);
endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: directed corner cases, then random traffic with random back-pressure.
// Accepted ops are modelled with plain integer arithmetic and checked when the response is presented.
module tb_addsub_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [7:0] op_count;

    addsub_arbiter_if bus();

    addsub_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] sum;
        logic        c;
        logic        v;
        int          acc;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         exp_prio = 0;
    logic [7:0] exp_count = 8'd0;
    bit         in_flight = 1'b0;
    bit         after_reset = 1'b0;
    bit         er0, er1, due;
    bit         rr_rand = 1'b0;
    bit         rr0 = 1'b1;
    bit         rr1 = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: unsigned sum for value/carry, signed sum for overflow range.
    function automatic void ref_op(input logic [15:0] a, input logic [15:0] b, input logic m,
                                   output logic [15:0] s, output logic c, output logic v);
        int ua, ub, sa, sb_s, full, sres;
        ua   = a;
        ub   = b;
        sa   = $signed(a);
        sb_s = $signed(b);
        if (!m) begin
            full = ua + ub;
            sres = sa + sb_s;
        end else begin
            full = ua + (65535 - ub) + 1;
            sres = sa - sb_s;
        end
        s = full[15:0];
        c = full[16];
        v = (sres > 32767) || (sres < -32768);
    endfunction

    // Monitor: predicts handshakes, scores responses, pushes accepted ops.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            check("req0_ready_in_reset", bus.req0_ready, 0);
            check("req1_ready_in_reset", bus.req1_ready, 0);
            sb.delete();
            in_flight   = 1'b0;
            exp_prio    = 0;
            exp_count   = 8'd0;
            after_reset = 1'b1;
        end else begin
            if (after_reset) begin
                check("rsp_sum_after_reset", bus.rsp_sum, 0);
                check("rsp_carry_after_reset", bus.rsp_carry, 0);
                check("rsp_overflow_after_reset", bus.rsp_overflow, 0);
                after_reset = 1'b0;
            end
            er0 = !in_flight && bus.req0_valid && (!bus.req1_valid || exp_prio == 0);
            er1 = !in_flight && bus.req1_valid && (!bus.req0_valid || exp_prio == 1);
            check("req0_ready", bus.req0_ready, er0);
            check("req1_ready", bus.req1_ready, er1);
            check("busy", busy, in_flight);
            check("op_count", op_count, exp_count);
            if (in_flight) begin
                due = (cyc >= sb[0].acc + 2);
                check("rsp0_valid", bus.rsp0_valid, due && sb[0].id == 0);
                check("rsp1_valid", bus.rsp1_valid, due && sb[0].id == 1);
                if (due) begin
                    check("rsp_sum", bus.rsp_sum, sb[0].sum);
                    check("rsp_carry", bus.rsp_carry, sb[0].c);
                    check("rsp_overflow", bus.rsp_overflow, sb[0].v);
                    if ((sb[0].id == 0 && bus.rsp0_ready) || (sb[0].id == 1 && bus.rsp1_ready)) begin
                        exp_prio  = 1 - sb[0].id;
                        exp_count = exp_count + 8'd1;
                        void'(sb.pop_front());
                        in_flight = 1'b0;
                    end
                end
            end else begin
                check("rsp0_valid_idle", bus.rsp0_valid, 0);
                check("rsp1_valid_idle", bus.rsp1_valid, 0);
            end
            if (er0 || er1) begin
                e.id  = er1 ? 1 : 0;
                e.acc = cyc;
                if (er1) ref_op(bus.req1_a, bus.req1_b, bus.req1_mode, e.sum, e.c, e.v);
                else     ref_op(bus.req0_a, bus.req0_b, bus.req0_mode, e.sum, e.c, e.v);
                sb.push_back(e);
                in_flight = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rr_rand) begin
            bus.rsp0_ready = ($urandom_range(0, 2) != 0);
            bus.rsp1_ready = ($urandom_range(0, 2) != 0);
        end else begin
            bus.rsp0_ready = rr0;
            bus.rsp1_ready = rr1;
        end
    end

    // Present one op and hold it until accepted; operands are scrambled afterwards.
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input logic m);
        int  n;
        bit  got;
        if (id == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_mode = m; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_mode = m; bus.req1_valid = 1'b1;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            got = (id == 0) ? bus.req0_ready : bus.req1_ready;
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout req%0d: got no ready, expected ready within 400 cycles", id);
        end
        @(posedge clk);
        #1;
        if (id == 0) begin
            bus.req0_valid = 1'b0; bus.req0_a = 16'($urandom); bus.req0_b = 16'($urandom);
        end else begin
            bus.req1_valid = 1'b0; bus.req1_a = 16'($urandom); bus.req1_b = 16'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_idle", busy, 0);
    endtask

    task automatic random_traffic(input int id, input int count);
        int gap;
        for (int i = 0; i < count; i++) begin
            issue(id, 16'($urandom), 16'($urandom), 1'($urandom));
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete within 60000 cycles");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = 16'd0; bus.req0_b = 16'd0; bus.req0_mode = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = 16'd0; bus.req1_b = 16'd0; bus.req1_mode = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset while the response is being held: op dropped, no count.
        rr0 = 1'b0;
        issue(0, 16'h1234, 16'h1111, 1'b0);
        n = 0;
        while (!bus.rsp0_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rsp0_valid_before_reset", bus.rsp0_valid, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rr0 = 1'b1;

        // Both requesters waiting through reset: requester 0 wins first.
        @(posedge clk);
        #1;
        reset = 1'b1;
        fork
            issue(0, 16'hFFFF, 16'hFFFF, 1'b0);
            issue(1, 16'h7FFF, 16'h0001, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                reset = 1'b0;
            end
        join

        issue(1, 16'h8000, 16'h0001, 1'b1);

        // Continuous contention: grants must alternate.
        fork
            begin repeat (4) issue(0, 16'h0005, 16'h0003, 1'b1); end
            begin repeat (4) issue(1, 16'h0003, 16'h0005, 1'b1); end
        join
        drain();

        // Back-pressure on requester 0 while requester 1 waits.
        rr0 = 1'b0;
        issue(0, 16'h4321, 16'h1234, 1'b0);
        fork
            issue(1, 16'hABCD, 16'h00FF, 1'b1);
            begin
                repeat (12) @(posedge clk);
                #1;
                rr0 = 1'b1;
            end
        join
        drain();

        // Random traffic; enough completions to wrap op_count.
        rr_rand = 1'b1;
        fork
            random_traffic(0, 160);
            random_traffic(1, 160);
        join
        drain();
        rr_rand = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        check("final_op_count", op_count, exp_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer that shares one 16-bit `AddSub` adder/subtractor between two requesters. Each requester submits an operand pair and a mode over a valid/ready handshake. The block drives the shared `AddSub` instance, registers its sum/carry/overflow, and returns the result on that requester's response channel. It sits between the instruction front-ends and the single arithmetic datapath.

## Interface
Parameters:
- none; width fixed at 16 to match `AddSub`.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req0_valid` / `req1_valid`  in  1  requester n has an operation pending.
- `req0_ready` / `req1_ready`  out  1  block accepts requester n's operands this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  16  operands.
- `req0_mode` / `req1_mode`  in  1  0 = A+B, 1 = A−B.
- `rsp0_valid` / `rsp1_valid`  out  1  result for requester n is presented.
- `rsp0_ready` / `rsp1_ready`  in  1  requester n takes the result.
- `rsp_sum`  out  16  registered sum, shared by both response channels.
- `rsp_carry`  out  1  carry-out c16; in subtract mode, 1 = no borrow.
- `rsp_overflow`  out  1  signed overflow, c16 XOR c15.
- `busy`  out  1  high in any state other than IDLE.
- `op_count`  out  8  completed operations, wraps 255→0.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- Priority pointer `prio` resets to 0, meaning requester 0 wins ties.
- **IDLE**
  - One requester valid: its `reqN_ready` is asserted combinationally in the same cycle.
  - Both valid: only the `prio` requester gets ready.
  - On valid&ready, latch a, b, mode and grant id; go to EXEC.
  - No valid: stay in IDLE.
  - `reqN_ready` is never high outside IDLE and is never high for both requesters in one cycle.
- **EXEC**
  - Latched operands drive the shared `AddSub` (inputA, inputB, mode).
  - Capture sum, carry and overflow into the result registers at the end of the cycle; go to RESP.
- **RESP**
  - Assert `rspN_valid` for the granted id only.
  - `rsp_sum`, `rsp_carry` and `rsp_overflow` hold stable while valid is high.
  - On `rspN_ready`: set `prio` to the other id, increment `op_count`, go to IDLE.
  - `rspN_ready` from the non-granted requester is ignored.
- Arithmetic is modulo 2^16. Subtraction is A + ~B + 1. Overflow is signed two's-complement overflow.
- Request inputs are sampled only at acceptance; later changes do not affect the op in flight.

## Timing
- Reset values: all `req*_ready`=0, `rsp*_valid`=0, `rsp_sum`=0, `rsp_carry`=0, `rsp_overflow`=0, `busy`=0, `op_count`=0, `prio`=0, state IDLE.
- Accept in cycle N. EXEC in N+1. `rspN_valid` first high in N+2.
- Latency: 2 cycles from acceptance to response valid.
- Response handshake in cycle M: `rspN_valid` is low in M+1, and a new accept is possible in M+1.
- Peak throughput is one op per 3 cycles.
- Back-pressure: `rspN_ready` held low keeps RESP and its outputs indefinitely; no new request is accepted meanwhile.
- `rspN_ready` already high on entry to RESP completes the response in that same first RESP cycle.
- A requester still valid after its response completes wins again only if the other requester is idle.
- Reset asserted mid-operation (EXEC or RESP): the op is dropped with no response. The next cycle shows reset values, and `op_count` does not increment.
- `op_count` at 255 plus one completion gives 0.

## Test plan
- Reset with both `reqN_valid` high → no `req*_ready` during reset; after release, requester 0 is accepted first (`prio`=0).
- req0: 0xFFFF + 0xFFFF, mode 0 → `rsp0_valid` 2 cycles after accept; sum 0xFFFE, carry 1, overflow 0; `op_count`=1.
- req1: 0x7FFF + 0x0001, mode 0 → sum 0x8000, carry 0, overflow 1. req1: 0x8000 − 0x0001 → sum 0x7FFF, carry 1, overflow 1.
- Both valid continuously; req0 = 0x0005 − 0x0003, req1 = 0x0003 − 0x0005 → grants alternate 0,1,0,1. Results 0x0002/carry 1 and 0xFFFE/carry 0, both overflow 0, on the correct `rspN` only.
- Hold `rsp0_ready` low for 10 cycles with req1 valid → outputs stable, `req1_ready` stays 0. Raise `rsp0_ready` → req1 accepted the next cycle.
- Assert `reset` during RESP → `rsp0_valid` and `busy` are 0 the next cycle, `op_count` is unchanged at 0. Separately, 256 completions → `op_count` reads 0.
